// File: rtl/mem_stage.sv
// mem_stage
//
// Memory-access pipeline stage between the ex_mem register and writeback.
// Non-memory ops pass straight through as a registered writeback record.
// Loads and stores run over a request/grant/rvalid data bus. Load data is
// lane-selected and extended before it is written back. Upstream is held
// off (mem_ready_o low) while a bus transaction is in flight.
//
// Optional feature macro: MEM_MISALIGN_TRAP_EN
//   defined   : misaligned half/word accesses are trapped at accept. They make
//               no bus request and emit a record with mem_misalign_o set.
//   undefined : no check. The access goes to the aligned word, and
//               mem_misalign_o is tied low.
//
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   ex_mem_valid_i           instruction present on the ex_mem inputs
//   mem_ready_o              stage can accept (FSM idle)
//   ex_mem_op_c_i            ALU result / memory address
//   ex_mem_store_data_i      store data
//   ex_mem_reg_waddr_i       destination register
//   ex_mem_reg_we_i          register write enable
//   ex_mem_mem_rd_i          load (wins if store is also set)
//   ex_mem_mem_wr_i          store
//   ex_mem_mem_size_i        0 byte, 1 half, 2/3 word
//   ex_mem_mem_unsigned_i    zero-extend load data
//   dbus_req_o/gnt_i         bus request / grant
//   dbus_we_o                bus write
//   dbus_addr_o              word-aligned bus address
//   dbus_be_o                byte enables
//   dbus_wdata_o             lane-replicated store data
//   dbus_rvalid_i/rdata_i    load response
//   mem_valid_o              one-cycle writeback record strobe
//   mem_wdata_o              writeback data
//   mem_reg_waddr_o          writeback register
//   mem_reg_we_o             writeback enable
//   mem_misalign_o           misaligned-access flag
module mem_stage (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ex_mem_valid_i,
   output logic        mem_ready_o,
   input  logic [31:0] ex_mem_op_c_i,
   input  logic [31:0] ex_mem_store_data_i,
   input  logic [4:0]  ex_mem_reg_waddr_i,
   input  logic        ex_mem_reg_we_i,
   input  logic        ex_mem_mem_rd_i,
   input  logic        ex_mem_mem_wr_i,
   input  logic [1:0]  ex_mem_mem_size_i,
   input  logic        ex_mem_mem_unsigned_i,
   output logic        dbus_req_o,
   input  logic        dbus_gnt_i,
   output logic        dbus_we_o,
   output logic [31:0] dbus_addr_o,
   output logic [3:0]  dbus_be_o,
   output logic [31:0] dbus_wdata_o,
   input  logic        dbus_rvalid_i,
   input  logic [31:0] dbus_rdata_i,
   output logic        mem_valid_o,
   output logic [31:0] mem_wdata_o,
   output logic [4:0]  mem_reg_waddr_o,
   output logic        mem_reg_we_o,
   output logic        mem_misalign_o
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REQ    = 2'd1,
      WAIT_R = 2'd2
   } state_t;

   state_t      state;

   logic [1:0]  size_q;
   logic        unsigned_q;
   logic [1:0]  lane_q;
   logic [4:0]  waddr_q;
   logic        we_q;

   logic        is_mem;
   logic [3:0]  be_req;
   logic [31:0] wdata_req;
   logic [7:0]  load_byte;
   logic [15:0] load_half;
   logic [31:0] load_fmt;

   assign mem_ready_o = (state == IDLE);
   assign is_mem      = ex_mem_mem_rd_i | ex_mem_mem_wr_i;

   // Byte enables and replicated store data are derived from the incoming
   // instruction so they can be registered onto the bus at accept and then
   // held unchanged until the grant arrives.
   always_comb begin
      be_req    = 4'b1111;
      wdata_req = ex_mem_store_data_i;
      case (ex_mem_mem_size_i)
         2'd0: begin
            be_req    = 4'b0001 << ex_mem_op_c_i[1:0];
            wdata_req = {4{ex_mem_store_data_i[7:0]}};
         end
         2'd1: begin
            be_req    = ex_mem_op_c_i[1] ? 4'b1100 : 4'b0011;
            wdata_req = {2{ex_mem_store_data_i[15:0]}};
         end
         default: begin
            be_req    = 4'b1111;
            wdata_req = ex_mem_store_data_i;
         end
      endcase
   end

   // Load formatting uses the byte lane latched at accept, since the ex_mem
   // inputs may already hold the next instruction when the data returns.
   always_comb begin
      load_byte = dbus_rdata_i[7:0];
      case (lane_q)
         2'd0:    load_byte = dbus_rdata_i[7:0];
         2'd1:    load_byte = dbus_rdata_i[15:8];
         2'd2:    load_byte = dbus_rdata_i[23:16];
         default: load_byte = dbus_rdata_i[31:24];
      endcase
      load_half = lane_q[1] ? dbus_rdata_i[31:16] : dbus_rdata_i[15:0];
      case (size_q)
         2'd0:    load_fmt = unsigned_q ? {24'd0, load_byte}
                                        : {{24{load_byte[7]}}, load_byte};
         2'd1:    load_fmt = unsigned_q ? {16'd0, load_half}
                                        : {{16{load_half[15]}}, load_half};
         default: load_fmt = dbus_rdata_i;
      endcase
   end

`ifdef MEM_MISALIGN_TRAP_EN
   logic misalign_req;

   // A half needs bit 0 clear and a word needs both low bits clear. Sizes 2
   // and 3 are both words, so size[1] selects the word rule.
   always_comb begin
      misalign_req = ((ex_mem_mem_size_i == 2'd1) && ex_mem_op_c_i[0]) ||
                     (ex_mem_mem_size_i[1] && (ex_mem_op_c_i[1:0] != 2'b00));
   end
`else
   assign mem_misalign_o = 1'b0;
`endif

   // Main FSM with registered bus and writeback outputs. mem_valid_o defaults
   // low every cycle, so each record is a single-cycle pulse. An async reset
   // drops dbus_req_o at once and discards any in-flight instruction.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= IDLE;
         size_q          <= 2'd0;
         unsigned_q      <= 1'b0;
         lane_q          <= 2'd0;
         waddr_q         <= 5'd0;
         we_q            <= 1'b0;
         dbus_req_o      <= 1'b0;
         dbus_we_o       <= 1'b0;
         dbus_addr_o     <= 32'd0;
         dbus_be_o       <= 4'd0;
         dbus_wdata_o    <= 32'd0;
         mem_valid_o     <= 1'b0;
         mem_wdata_o     <= 32'd0;
         mem_reg_waddr_o <= 5'd0;
         mem_reg_we_o    <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
         mem_misalign_o  <= 1'b0;
`endif
      end else begin
         mem_valid_o <= 1'b0;
         case (state)
            IDLE: begin
               if (ex_mem_valid_i) begin
                  if (!is_mem) begin
                     mem_valid_o     <= 1'b1;
                     mem_wdata_o     <= ex_mem_op_c_i;
                     mem_reg_waddr_o <= ex_mem_reg_waddr_i;
                     mem_reg_we_o    <= ex_mem_reg_we_i;
`ifdef MEM_MISALIGN_TRAP_EN
                     mem_misalign_o  <= 1'b0;
                  end else if (misalign_req) begin
                     mem_valid_o     <= 1'b1;
                     mem_wdata_o     <= ex_mem_op_c_i;
                     mem_reg_waddr_o <= ex_mem_reg_waddr_i;
                     mem_reg_we_o    <= 1'b0;
                     mem_misalign_o  <= 1'b1;
`endif
                  end else begin
                     size_q       <= ex_mem_mem_size_i;
                     unsigned_q   <= ex_mem_mem_unsigned_i;
                     lane_q       <= ex_mem_op_c_i[1:0];
                     waddr_q      <= ex_mem_reg_waddr_i;
                     we_q         <= ex_mem_reg_we_i;
                     dbus_req_o   <= 1'b1;
                     dbus_we_o    <= ~ex_mem_mem_rd_i;
                     dbus_addr_o  <= {ex_mem_op_c_i[31:2], 2'b00};
                     dbus_be_o    <= be_req;
                     dbus_wdata_o <= wdata_req;
                     state        <= REQ;
                  end
               end
            end
            REQ: begin
               if (dbus_gnt_i) begin
                  dbus_req_o <= 1'b0;
                  if (dbus_we_o) begin
                     state           <= IDLE;
                     mem_valid_o     <= 1'b1;
                     mem_wdata_o     <= {dbus_addr_o[31:2], lane_q};
                     mem_reg_waddr_o <= waddr_q;
                     mem_reg_we_o    <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
                     mem_misalign_o  <= 1'b0;
`endif
                  end else begin
                     state <= WAIT_R;
                  end
               end
            end
            WAIT_R: begin
               if (dbus_rvalid_i) begin
                  state           <= IDLE;
                  mem_valid_o     <= 1'b1;
                  mem_wdata_o     <= load_fmt;
                  mem_reg_waddr_o <= waddr_q;
                  mem_reg_we_o    <= we_q;
`ifdef MEM_MISALIGN_TRAP_EN
                  mem_misalign_o  <= 1'b0;
`endif
               end
            end
            default: begin
               state      <= IDLE;
               dbus_req_o <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage
//
// Self-checking bench for mem_stage. Each instruction's expected bus fields
// and writeback record come from plain arithmetic on addresses and sizes.
// The bus responder grants and returns data after random delays, and the
// exact cycle at which each record appears is checked.
module tb_mem_stage;

`ifdef MEM_MISALIGN_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   logic        clk;
   logic        rst_n;
   logic        ex_mem_valid_i;
   logic        mem_ready_o;
   logic [31:0] ex_mem_op_c_i;
   logic [31:0] ex_mem_store_data_i;
   logic [4:0]  ex_mem_reg_waddr_i;
   logic        ex_mem_reg_we_i;
   logic        ex_mem_mem_rd_i;
   logic        ex_mem_mem_wr_i;
   logic [1:0]  ex_mem_mem_size_i;
   logic        ex_mem_mem_unsigned_i;
   logic        dbus_req_o;
   logic        dbus_gnt_i;
   logic        dbus_we_o;
   logic [31:0] dbus_addr_o;
   logic [3:0]  dbus_be_o;
   logic [31:0] dbus_wdata_o;
   logic        dbus_rvalid_i;
   logic [31:0] dbus_rdata_i;
   logic        mem_valid_o;
   logic [31:0] mem_wdata_o;
   logic [4:0]  mem_reg_waddr_o;
   logic        mem_reg_we_o;
   logic        mem_misalign_o;

   int assertCount = 0;
   int failCount   = 0;

   mem_stage dut (
      .clk                   (clk),
      .rst_n                 (rst_n),
      .ex_mem_valid_i        (ex_mem_valid_i),
      .mem_ready_o           (mem_ready_o),
      .ex_mem_op_c_i         (ex_mem_op_c_i),
      .ex_mem_store_data_i   (ex_mem_store_data_i),
      .ex_mem_reg_waddr_i    (ex_mem_reg_waddr_i),
      .ex_mem_reg_we_i       (ex_mem_reg_we_i),
      .ex_mem_mem_rd_i       (ex_mem_mem_rd_i),
      .ex_mem_mem_wr_i       (ex_mem_mem_wr_i),
      .ex_mem_mem_size_i     (ex_mem_mem_size_i),
      .ex_mem_mem_unsigned_i (ex_mem_mem_unsigned_i),
      .dbus_req_o            (dbus_req_o),
      .dbus_gnt_i            (dbus_gnt_i),
      .dbus_we_o             (dbus_we_o),
      .dbus_addr_o           (dbus_addr_o),
      .dbus_be_o             (dbus_be_o),
      .dbus_wdata_o          (dbus_wdata_o),
      .dbus_rvalid_i         (dbus_rvalid_i),
      .dbus_rdata_i          (dbus_rdata_i),
      .mem_valid_o           (mem_valid_o),
      .mem_wdata_o           (mem_wdata_o),
      .mem_reg_waddr_o       (mem_reg_waddr_o),
      .mem_reg_we_o          (mem_reg_we_o),
      .mem_misalign_o        (mem_misalign_o)
   );

   // Free-running clock, first rising edge at 5.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case the run gets stuck.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Compare one observed value with its expected value and log any mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      assertCount++;
      if (got !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Byte enables from the size and the address offset within the word.
   function automatic logic [3:0] model_be(input logic [1:0] sz, input logic [31:0] addr);
      int unsigned off;
      off = addr % 32'd4;
      if (sz == 2'd0) return 4'((1 << off) & 15);
      if (sz == 2'd1) return 4'((3 << (2 * (off / 2))) & 15);
      return 4'hF;
   endfunction

   // Store data copied into every lane of the access size.
   function automatic logic [31:0] model_store(input logic [1:0] sz, input logic [31:0] sd);
      if (sz == 2'd0) return (sd & 32'h0000_00FF) * 32'h0101_0101;
      if (sz == 2'd1) return (sd & 32'h0000_FFFF) * 32'h0001_0001;
      return sd;
   endfunction

   // Load value: shift the addressed lane down, mask it, then extend.
   function automatic logic [31:0] model_load(input logic [1:0] sz, input logic uns,
                                              input logic [31:0] addr, input logic [31:0] rdata);
      int               bits;
      int               shift;
      longint unsigned  v;
      longint unsigned  mask;
      if (sz == 2'd0) begin
         bits  = 8;
         shift = 8 * int'(addr % 32'd4);
      end else if (sz == 2'd1) begin
         bits  = 16;
         shift = 16 * int'((addr / 32'd2) % 32'd2);
      end else begin
         bits  = 32;
         shift = 0;
      end
      v    = longint'(rdata) >> shift;
      mask = (64'd1 << bits) - 64'd1;
      v    = v & mask;
      if (!uns && (bits < 32) && (((v >> (bits - 1)) & 64'd1) != 64'd0))
         v = v | ~mask;
      return 32'(v & 64'hFFFF_FFFF);
   endfunction

   function automatic bit model_misaligned(input logic [1:0] sz, input logic [31:0] addr);
      if (sz == 2'd1) return (addr % 32'd2) != 0;
      if (sz >= 2'd2) return (addr % 32'd4) != 0;
      return 1'b0;
   endfunction

   // Drive one instruction, play the bus side with the given grant and
   // response delays, and check the bus fields and the record cycle by cycle.
   task automatic applyStimulus(input logic [31:0] opc, input logic [31:0] sd,
                                input logic [4:0] wa, input logic we,
                                input logic rd, input logic wr,
                                input logic [1:0] sz, input logic uns,
                                input int gw, input int rw, input logic [31:0] rdata);
      bit          is_mem;
      bit          is_store;
      bit          mis;
      logic [31:0] exp_addr;
      is_mem   = rd || wr;
      is_store = wr && !rd;
      mis      = is_mem && TRAP && model_misaligned(sz, opc);
      exp_addr = opc & 32'hFFFF_FFFC;

      @(negedge clk);
      checkOutput("valid_is_pulse", mem_valid_o, 1'b0);
      checkOutput("ready_idle", mem_ready_o, 1'b1);
      ex_mem_valid_i        = 1'b1;
      ex_mem_op_c_i         = opc;
      ex_mem_store_data_i   = sd;
      ex_mem_reg_waddr_i    = wa;
      ex_mem_reg_we_i       = we;
      ex_mem_mem_rd_i       = rd;
      ex_mem_mem_wr_i       = wr;
      ex_mem_mem_size_i     = sz;
      ex_mem_mem_unsigned_i = uns;

      @(negedge clk);
      ex_mem_valid_i        = 1'b0;
      ex_mem_op_c_i         = $urandom;
      ex_mem_store_data_i   = $urandom;
      ex_mem_mem_size_i     = 2'($urandom_range(0, 3));
      ex_mem_mem_unsigned_i = 1'($urandom_range(0, 1));

      if (!is_mem || mis) begin
         checkOutput("rec_valid", mem_valid_o, 1'b1);
         checkOutput("rec_wdata", mem_wdata_o, opc);
         checkOutput("rec_we", mem_reg_we_o, mis ? 1'b0 : we);
         checkOutput("rec_misalign", mem_misalign_o, mis);
         checkOutput("no_req", dbus_req_o, 1'b0);
         checkOutput("ready_after", mem_ready_o, 1'b1);
         if (!mis) checkOutput("rec_waddr", mem_reg_waddr_o, wa);
         return;
      end

      for (int i = 0; i <= gw; i++) begin
         checkOutput("req_high", dbus_req_o, 1'b1);
         checkOutput("req_addr", dbus_addr_o, exp_addr);
         checkOutput("req_be", dbus_be_o, model_be(sz, opc));
         checkOutput("req_we", dbus_we_o, is_store);
         if (is_store) checkOutput("req_wdata", dbus_wdata_o, model_store(sz, sd));
         checkOutput("req_ready_low", mem_ready_o, 1'b0);
         checkOutput("req_no_rec", mem_valid_o, 1'b0);
         dbus_rvalid_i = 1'($urandom_range(0, 1));
         dbus_rdata_i  = $urandom;
         if (i == gw) dbus_gnt_i = 1'b1;
         @(negedge clk);
         dbus_gnt_i    = 1'b0;
         dbus_rvalid_i = 1'b0;
      end

      if (is_store) begin
         checkOutput("st_rec_valid", mem_valid_o, 1'b1);
         checkOutput("st_rec_we", mem_reg_we_o, 1'b0);
         checkOutput("st_rec_misalign", mem_misalign_o, 1'b0);
         checkOutput("st_ready", mem_ready_o, 1'b1);
         return;
      end

      for (int i = 0; i <= rw; i++) begin
         checkOutput("wait_req_low", dbus_req_o, 1'b0);
         checkOutput("wait_ready_low", mem_ready_o, 1'b0);
         checkOutput("wait_no_rec", mem_valid_o, 1'b0);
         if (i == rw) begin
            dbus_rvalid_i = 1'b1;
            dbus_rdata_i  = rdata;
         end
         @(negedge clk);
         dbus_rvalid_i = 1'b0;
         dbus_rdata_i  = $urandom;
      end

      checkOutput("ld_rec_valid", mem_valid_o, 1'b1);
      checkOutput("ld_rec_wdata", mem_wdata_o, model_load(sz, uns, opc, rdata));
      checkOutput("ld_rec_waddr", mem_reg_waddr_o, wa);
      checkOutput("ld_rec_we", mem_reg_we_o, we);
      checkOutput("ld_rec_misalign", mem_misalign_o, 1'b0);
      checkOutput("ld_ready", mem_ready_o, 1'b1);
   endtask

   // Start a word load, optionally take it into WAIT_R, then reset it away
   // and send a stray response after release.
   task automatic resetMidFlight(input bit in_wait);
      @(negedge clk);
      ex_mem_valid_i    = 1'b1;
      ex_mem_op_c_i     = 32'h0000_0040;
      ex_mem_mem_rd_i   = 1'b1;
      ex_mem_mem_wr_i   = 1'b0;
      ex_mem_mem_size_i = 2'd2;
      ex_mem_reg_we_i   = 1'b1;
      @(negedge clk);
      ex_mem_valid_i  = 1'b0;
      ex_mem_mem_rd_i = 1'b0;
      checkOutput("rst_req_before", dbus_req_o, 1'b1);
      if (in_wait) begin
         dbus_gnt_i = 1'b1;
         @(negedge clk);
         dbus_gnt_i = 1'b0;
         checkOutput("rst_in_wait", mem_ready_o, 1'b0);
      end
      #2 rst_n = 1'b0;
      #1;
      checkOutput("rst_req_drop", dbus_req_o, 1'b0);
      checkOutput("rst_ready", mem_ready_o, 1'b1);
      @(negedge clk);
      rst_n         = 1'b1;
      dbus_rvalid_i = 1'b1;
      dbus_rdata_i  = 32'hDEAD_BEEF;
      @(negedge clk);
      dbus_rvalid_i = 1'b0;
      checkOutput("stray_no_rec", mem_valid_o, 1'b0);
      checkOutput("stray_ready", mem_ready_o, 1'b1);
      @(negedge clk);
      checkOutput("stray_no_rec2", mem_valid_o, 1'b0);
      checkOutput("stray_no_req", dbus_req_o, 1'b0);
   endtask

   initial begin
      ex_mem_valid_i        = 1'b0;
      ex_mem_op_c_i         = 32'd0;
      ex_mem_store_data_i   = 32'd0;
      ex_mem_reg_waddr_i    = 5'd0;
      ex_mem_reg_we_i       = 1'b0;
      ex_mem_mem_rd_i       = 1'b0;
      ex_mem_mem_wr_i       = 1'b0;
      ex_mem_mem_size_i     = 2'd0;
      ex_mem_mem_unsigned_i = 1'b0;
      dbus_gnt_i            = 1'b0;
      dbus_rvalid_i         = 1'b0;
      dbus_rdata_i          = 32'd0;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      checkOutput("rst_valid", mem_valid_o, 1'b0);
      checkOutput("rst_ready", mem_ready_o, 1'b1);
      checkOutput("rst_req", dbus_req_o, 1'b0);
      checkOutput("rst_dbus_we", dbus_we_o, 1'b0);
      checkOutput("rst_addr", dbus_addr_o, 32'd0);
      checkOutput("rst_be", dbus_be_o, 4'd0);
      checkOutput("rst_dbus_wdata", dbus_wdata_o, 32'd0);
      checkOutput("rst_wdata", mem_wdata_o, 32'd0);
      checkOutput("rst_waddr", mem_reg_waddr_o, 5'd0);
      checkOutput("rst_reg_we", mem_reg_we_o, 1'b0);
      checkOutput("rst_misalign", mem_misalign_o, 1'b0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      applyStimulus(32'h0000_1234, 32'd0, 5'd5, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 0, 0, 32'd0);
      applyStimulus(32'h0000_0103, 32'h0000_00AB, 5'd2, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 0, 0, 32'd0);
      applyStimulus(32'h0000_0102, 32'd0, 5'd9, 1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 2, 1, 32'h8001_0000);
      applyStimulus(32'h0000_0102, 32'd0, 5'd9, 1'b1, 1'b1, 1'b0, 2'd1, 1'b1, 2, 1, 32'h8001_0000);
      applyStimulus(32'h0000_0201, 32'd0, 5'd4, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 0, 0, 32'h1122_3344);
      applyStimulus(32'h0000_0300, 32'd0, 5'd6, 1'b1, 1'b1, 1'b1, 2'd3, 1'b0, 1, 0, 32'hCAFE_F00D);

      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         ex_mem_valid_i     = 1'b1;
         ex_mem_op_c_i      = 32'h0000_5000 + 32'(i);
         ex_mem_reg_waddr_i = 5'(10 + i);
         ex_mem_reg_we_i    = 1'b1;
         ex_mem_mem_rd_i    = 1'b0;
         ex_mem_mem_wr_i    = 1'b0;
         @(negedge clk);
         checkOutput("b2b_alu_valid", mem_valid_o, 1'b1);
         checkOutput("b2b_alu_wdata", mem_wdata_o, 32'h0000_5000 + 32'(i));
         checkOutput("b2b_alu_ready", mem_ready_o, 1'b1);
      end
      ex_mem_valid_i = 1'b0;

      @(negedge clk);
      ex_mem_valid_i        = 1'b1;
      ex_mem_op_c_i         = 32'h0000_0101;
      ex_mem_reg_waddr_i    = 5'd3;
      ex_mem_reg_we_i       = 1'b1;
      ex_mem_mem_rd_i       = 1'b1;
      ex_mem_mem_wr_i       = 1'b0;
      ex_mem_mem_size_i     = 2'd0;
      ex_mem_mem_unsigned_i = 1'b0;
      @(negedge clk);
      ex_mem_op_c_i      = 32'h0000_CAFE;
      ex_mem_reg_waddr_i = 5'd7;
      ex_mem_mem_rd_i    = 1'b0;
      checkOutput("hold_ready_req", mem_ready_o, 1'b0);
      dbus_gnt_i = 1'b1;
      @(negedge clk);
      dbus_gnt_i = 1'b0;
      checkOutput("hold_ready_wait", mem_ready_o, 1'b0);
      checkOutput("hold_no_rec", mem_valid_o, 1'b0);
      dbus_rvalid_i = 1'b1;
      dbus_rdata_i  = 32'h0000_8000;
      @(negedge clk);
      dbus_rvalid_i = 1'b0;
      checkOutput("hold_ld_valid", mem_valid_o, 1'b1);
      checkOutput("hold_ld_wdata", mem_wdata_o, 32'hFFFF_FF80);
      checkOutput("hold_ld_waddr", mem_reg_waddr_o, 5'd3);
      checkOutput("hold_ready_back", mem_ready_o, 1'b1);
      @(negedge clk);
      ex_mem_valid_i = 1'b0;
      checkOutput("hold_alu_valid", mem_valid_o, 1'b1);
      checkOutput("hold_alu_wdata", mem_wdata_o, 32'h0000_CAFE);
      checkOutput("hold_alu_waddr", mem_reg_waddr_o, 5'd7);
      @(negedge clk);
      checkOutput("hold_no_dup", mem_valid_o, 1'b0);

      resetMidFlight(1'b0);
      resetMidFlight(1'b1);

      for (int n = 0; n < 150; n++) begin
         int kind;
         kind = $urandom_range(0, 3);
         applyStimulus($urandom, $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                       (kind == 1) || (kind == 3), (kind == 2) || (kind == 3),
                       2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                       $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
